// File: rtl/inta_sequencer.sv
// 8259 (8086 mode) interrupt acknowledge sequencer: raises INT, runs the two-pulse INTA cycle,
// drives the vector byte and owns the in-service register and priority rotation.
module inta_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] highest_req,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [2:0] priority_rotate,
  output logic [7:0] irr_clear,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {StIdle, StPend, StAck1, StWait2, StAck2} state_e;

  state_e     state_q, state_d;
  logic       inta_q;
  logic       int_q, int_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic [7:0] irr_clear_q, irr_clear_d;
  logic [7:0] data_q, data_d;
  logic       oe_q, oe_d;
  logic [2:0] ack_lvl_q, ack_lvl_d;
  logic       spur_q, spur_d;

  logic       inta_fall, inta_rise;
  logic       req_any;
  logic [2:0] req_lvl;
  logic       ns_found;
  logic [2:0] ns_lvl, scan_idx;
  logic       eoi_hit, aeoi_hit, aeoi_clr;
  logic [2:0] eoi_lvl;
  logic [7:0] set_mask, clr_mask;

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;
  assign req_any   = |highest_req;

  always_comb begin
    req_lvl = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (highest_req[i]) req_lvl = 3'(i);
    end
  end

  // Non-specific EOI: first set ISR bit starting at the current highest-priority level.
  always_comb begin
    ns_found = 1'b0;
    ns_lvl   = 3'd0;
    scan_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = rot_q + 3'(i);
      if (!ns_found && isr_q[scan_idx]) begin
        ns_found = 1'b1;
        ns_lvl   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    irr_clear_d = 8'h00;
    data_d      = data_q;
    oe_d        = oe_q;
    ack_lvl_d   = ack_lvl_q;
    spur_d      = spur_q;
    set_mask    = 8'h00;
    aeoi_clr    = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_any) begin
          int_d   = 1'b1;
          state_d = StPend;
        end
      end
      StPend: begin
        if (inta_fall) begin
          int_d   = 1'b0;
          state_d = StAck1;
          if (req_any) begin
            ack_lvl_d   = req_lvl;
            spur_d      = 1'b0;
            set_mask    = 8'h01 << req_lvl;
            irr_clear_d = 8'h01 << req_lvl;
          end else begin
            ack_lvl_d = 3'd7;
            spur_d    = 1'b1;
          end
        end
      end
      StAck1: begin
        if (inta_rise) state_d = StWait2;
      end
      StWait2: begin
        if (inta_fall) begin
          data_d  = {vector_base, ack_lvl_q};
          oe_d    = 1'b1;
          state_d = StAck2;
        end
      end
      StAck2: begin
        if (inta_rise) begin
          oe_d     = 1'b0;
          state_d  = StIdle;
          aeoi_clr = aeoi & ~spur_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clears are taken from the old ISR so a bit set this cycle is never cleared by it.
  always_comb begin
    eoi_hit = 1'b0;
    eoi_lvl = 3'd0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        eoi_hit = isr_q[eoi_level];
        eoi_lvl = eoi_level;
      end else begin
        eoi_hit = ns_found;
        eoi_lvl = ns_lvl;
      end
    end
    aeoi_hit = aeoi_clr & isr_q[ack_lvl_q];
    clr_mask = (eoi_hit ? (8'h01 << eoi_lvl) : 8'h00) |
               (aeoi_hit ? (8'h01 << ack_lvl_q) : 8'h00);
    isr_d    = (isr_q & ~clr_mask) | set_mask;
    rot_d    = rot_q;
    if (rotate_on_eoi) begin
      if (aeoi_hit)     rot_d = ack_lvl_q + 3'd1;
      else if (eoi_hit) rot_d = eoi_lvl + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      inta_q      <= 1'b1;
      int_q       <= 1'b0;
      isr_q       <= 8'h00;
      rot_q       <= 3'd0;
      irr_clear_q <= 8'h00;
      data_q      <= 8'h00;
      oe_q        <= 1'b0;
      ack_lvl_q   <= 3'd0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n;
      int_q       <= int_d;
      isr_q       <= isr_d;
      rot_q       <= rot_d;
      irr_clear_q <= irr_clear_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      ack_lvl_q   <= ack_lvl_d;
      spur_q      <= spur_d;
    end
  end

  assign int_out         = int_q;
  assign isr             = isr_q;
  assign priority_rotate = rot_q;
  assign irr_clear       = irr_clear_q;
  assign data_out        = data_q;
  assign data_oe         = oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed and randomized bench for inta_sequencer against a transaction-level model of the
// in-service register, rotation value and vector byte.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] highest_req;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic       int_out;
  logic [7:0] isr;
  logic [2:0] priority_rotate;
  logic [7:0] irr_clear;
  logic [7:0] data_out;
  logic       data_oe;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_isr;
  logic [2:0] m_rot;

  always #5 clk = ~clk;

  inta_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .highest_req    (highest_req),
    .inta_n         (inta_n),
    .vector_base    (vector_base),
    .aeoi           (aeoi),
    .eoi_cmd        (eoi_cmd),
    .eoi_specific   (eoi_specific),
    .eoi_level      (eoi_level),
    .rotate_on_eoi  (rotate_on_eoi),
    .int_out        (int_out),
    .isr            (isr),
    .priority_rotate(priority_rotate),
    .irr_clear      (irr_clear),
    .data_out       (data_out),
    .data_oe        (data_oe)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: clear level l if in service; the serviced level becomes lowest priority.
  task automatic m_clear(input int l, input logic r);
    if (m_isr[l]) begin
      m_isr[l] = 1'b0;
      if (r) m_rot = 3'((l + 1) % 8);
    end
  endtask

  task automatic m_nseoi(input logic r);
    int start;
    start = int'(m_rot);
    for (int i = 0; i < 8; i++) begin
      if (m_isr[(start + i) % 8]) begin
        m_clear((start + i) % 8, r);
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_int"}, {7'd0, int_out}, 8'h00);
    chk({tag, "_isr"}, isr, 8'h00);
    chk({tag, "_rot"}, {5'd0, priority_rotate}, 8'h00);
    chk({tag, "_irr"}, irr_clear, 8'h00);
    chk({tag, "_dout"}, data_out, 8'h00);
    chk({tag, "_oe"}, {7'd0, data_oe}, 8'h00);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    highest_req = 8'h00;
    inta_n      = 1'b1;
    eoi_cmd     = 1'b0;
    #2;
    check_all_zero("reset");
    m_isr = 8'h00;
    m_rot = 3'd0;
    #10;
    rst_n = 1'b1;
    step();
  endtask

  // Full acknowledge of request level lvl; drop withdraws the request before the 1st INTA.
  // An optional EOI is issued on the same cycle as the 1st INTA falling edge.
  task automatic run_ack(input int lvl, input logic drop, input logic a, input logic r,
                         input logic [4:0] base, input logic e_en, input logic e_spec,
                         input logic [2:0] e_lvl);
    logic [7:0] req;
    int         alvl;
    req           = 8'h01 << lvl;
    alvl          = drop ? 7 : lvl;
    vector_base   = base;
    aeoi          = a;
    rotate_on_eoi = r;
    highest_req   = req;
    step();
    chk("int_raise", {7'd0, int_out}, 8'h01);
    if (drop) begin
      highest_req = 8'h00;
      step();
      chk("int_hold", {7'd0, int_out}, 8'h01);
    end
    inta_n       = 1'b0;
    eoi_cmd      = e_en;
    eoi_specific = e_spec;
    eoi_level    = e_lvl;
    step();
    eoi_cmd     = 1'b0;
    highest_req = 8'h00;
    if (e_en) begin
      if (e_spec) m_clear(int'(e_lvl), r);
      else m_nseoi(r);
    end
    if (!drop) m_isr[lvl] = 1'b1;
    chk("irr_pulse", irr_clear, drop ? 8'h00 : req);
    chk("isr_set", isr, m_isr);
    chk("int_drop", {7'd0, int_out}, 8'h00);
    chk("rot_ack", {5'd0, priority_rotate}, {5'd0, m_rot});
    step();
    chk("irr_end", irr_clear, 8'h00);
    inta_n = 1'b1;
    step();
    chk("oe_gap", {7'd0, data_oe}, 8'h00);
    inta_n = 1'b0;
    step();
    chk("oe_on", {7'd0, data_oe}, 8'h01);
    chk("vector", data_out, {base, 3'(alvl)});
    step();
    chk("oe_hold", {7'd0, data_oe}, 8'h01);
    inta_n = 1'b1;
    step();
    if (a && !drop) m_clear(alvl, r);
    chk("oe_off", {7'd0, data_oe}, 8'h00);
    chk("isr_end", isr, m_isr);
    chk("rot_end", {5'd0, priority_rotate}, {5'd0, m_rot});
  endtask

  task automatic do_eoi(input logic spec, input logic [2:0] lvl, input logic r);
    eoi_cmd       = 1'b1;
    eoi_specific  = spec;
    eoi_level     = lvl;
    rotate_on_eoi = r;
    step();
    eoi_cmd = 1'b0;
    if (spec) m_clear(int'(lvl), r);
    else m_nseoi(r);
    chk("eoi_isr", isr, m_isr);
    chk("eoi_rot", {5'd0, priority_rotate}, {5'd0, m_rot});
  endtask

  initial begin
    rst_n         = 1'b0;
    highest_req   = 8'h00;
    inta_n        = 1'b1;
    vector_base   = 5'h00;
    aeoi          = 1'b0;
    eoi_cmd       = 1'b0;
    eoi_specific  = 1'b0;
    eoi_level     = 3'd0;
    rotate_on_eoi = 1'b0;
    m_isr         = 8'h00;
    m_rot         = 3'd0;
    step();
    do_reset();

    // Basic acknowledge of level 3, vector 0x83, ISR holds 0x08.
    run_ack(3, 1'b0, 1'b0, 1'b0, 5'h10, 1'b0, 1'b0, 3'd0);
    chk("t1_isr", isr, 8'h08);

    // AEOI with rotation.
    do_reset();
    run_ack(3, 1'b0, 1'b1, 1'b1, 5'h10, 1'b0, 1'b0, 3'd0);
    chk("t2_isr", isr, 8'h00);
    chk("t2_rot", {5'd0, priority_rotate}, 8'h04);

    // Non-specific EOI from rotate 0, then from rotate 4.
    do_reset();
    run_ack(1, 1'b0, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0, 3'd0);
    run_ack(3, 1'b0, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0, 3'd0);
    do_eoi(1'b0, 3'd0, 1'b0);
    chk("t3a_isr", isr, 8'h08);
    run_ack(3, 1'b0, 1'b1, 1'b1, 5'h02, 1'b0, 1'b0, 3'd0);
    run_ack(7, 1'b0, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0, 3'd0);
    run_ack(3, 1'b0, 1'b0, 1'b0, 5'h02, 1'b0, 1'b0, 3'd0);
    chk("t3b_pre", isr, 8'h88);
    do_eoi(1'b0, 3'd0, 1'b0);
    chk("t3b_isr", isr, 8'h08);

    // Spurious: request withdrawn before the 1st INTA.
    do_reset();
    run_ack(0, 1'b1, 1'b1, 1'b0, 5'h15, 1'b0, 1'b0, 3'd0);
    chk("t4_isr", isr, 8'h00);

    // Specific EOI level 2 coincident with the 1st INTA for level 5.
    do_reset();
    run_ack(2, 1'b0, 1'b0, 1'b0, 5'h08, 1'b0, 1'b0, 3'd0);
    run_ack(5, 1'b0, 1'b0, 1'b0, 5'h08, 1'b1, 1'b1, 3'd2);
    chk("t5_isr", isr, 8'h20);

    // Reset between the two INTA pulses, then a clean restart.
    do_reset();
    vector_base = 5'h1f;
    highest_req = 8'h40;
    step();
    inta_n = 1'b0;
    step();
    highest_req = 8'h00;
    inta_n      = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_midreset");
    #10;
    rst_n = 1'b1;
    m_isr = 8'h00;
    m_rot = 3'd0;
    step();
    run_ack(6, 1'b0, 1'b0, 1'b0, 5'h1f, 1'b0, 1'b0, 3'd0);
    chk("t6_isr", isr, 8'h40);

    // Randomized transactions and EOIs.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      run_ack(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1'($urandom),
              1'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
              3'($urandom));
      if ($urandom_range(0, 1) == 1) do_eoi(1'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
